// File: rtl/adc_capture.sv
// ---------------------------------------------------------------------------
// adc_capture
//
// Triggered sample-capture engine for the scope path. Samples a parallel ADC
// bus on the sample clock, decimates it, keeps a pre/post-trigger window in a
// circular buffer and then streams that window out oldest-first over a
// valid/ready port.
//
// Ports
//   clkin       sample clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   adc_data    ADC parallel sample, valid every cycle
//   start       one-cycle arm request, ignored while busy
//   decim       store one sample every decim+1 cycles (latched on start)
//   trig_level  unsigned trigger threshold (latched on start)
//   trig_edge   0 = rising, 1 = falling (latched on start)
//   trig_force  level-sensitive forced trigger, honoured only when armed
//   pretrig     samples kept before the trigger sample (latched on start)
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse after the last readout beat
//   rd_data     readout sample
//   rd_valid    rd_data valid
//   rd_ready    consumer accepts the beat
// ---------------------------------------------------------------------------
module adc_capture #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int DIV_W = 16
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [DW-1:0]    adc_data,
    input  logic             start,
    input  logic [DIV_W-1:0] decim,
    input  logic [DW-1:0]    trig_level,
    input  logic             trig_edge,
    input  logic             trig_force,
    input  logic [AW-1:0]    pretrig,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int            DEPTH     = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = '1;   // DEPTH-1

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, READOUT} state_t;

    state_t state, state_d;

    // Capture configuration, frozen for the whole capture. pretrig is AW bits
    // wide, so latching it already bounds it to DEPTH-1.
    logic [DIV_W-1:0] decim_q;
    logic [DW-1:0]    level_q;
    logic             edge_q;
    logic [AW-1:0]    pretrig_q;

    logic [DIV_W-1:0] div_cnt;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;        // address of the beat currently presented
    logic [AW-1:0]    post_left;   // samples still to store after the trigger
    logic [AW-1:0]    beat_cnt;
    logic [DW-1:0]    prev_q;      // last stored sample, for edge detection
    logic             have_prev;

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    ram_addr;

    logic capturing, strobe, edge_hit, trig_hit, wr_en, pre_full, fire, last_beat;

    // NOTE: every signal gets a default before any branch, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    always_comb begin
        capturing = (state == PRE) || (state == ARMED) || (state == POST);
        strobe    = capturing && (div_cnt == '0);

        if (edge_q) edge_hit = (prev_q > level_q) && (adc_data <= level_q);
        else        edge_hit = (prev_q < level_q) && (adc_data >= level_q);

        // The first sample of a capture has no predecessor, so only a forced
        // trigger can fire on it.
        trig_hit  = (state == ARMED) && strobe && (trig_force || (have_prev && edge_hit));
        wr_en     = strobe && !((state == POST) && (post_left == '0));
        pre_full  = (({1'b0, wptr} + (AW+1)'(1)) == {1'b0, pretrig_q});
        fire      = rd_valid && rd_ready;
        last_beat = fire && (beat_cnt == LAST_ADDR);

        // Read one address ahead on a transfer so the RAM's one-cycle latency
        // is hidden; while stalled the same address is re-read, which keeps
        // rd_data stable because nothing is written during readout.
        ram_addr  = fire ? (rptr + AW'(1)) : rptr;

        busy      = (state != IDLE);

        state_d   = state;
        unique case (state)
            IDLE:    if (start) state_d = (pretrig == '0) ? ARMED : PRE;
            PRE:     if (strobe && pre_full) state_d = ARMED;
            ARMED:   if (trig_hit) state_d = POST;
            POST:    if ((post_left == '0) || (strobe && (post_left == AW'(1))))
                         state_d = READOUT;
            READOUT: if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            div_cnt   <= '0;
            post_left <= '0;
            beat_cnt  <= '0;
            have_prev <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_d;
            done     <= last_beat;
            rd_valid <= (state == READOUT) && !last_beat;

            if ((state == IDLE) && start) begin
                decim_q   <= decim;
                level_q   <= trig_level;
                edge_q    <= trig_edge;
                pretrig_q <= pretrig;
                wptr      <= '0;
                div_cnt   <= '0;          // first strobe on the next cycle
                beat_cnt  <= '0;
                have_prev <= 1'b0;
            end else if (capturing) begin
                div_cnt <= (div_cnt == '0) ? decim_q : div_cnt - DIV_W'(1);
            end

            if (wr_en) begin
                wptr      <= wptr + AW'(1);
                prev_q    <= adc_data;
                have_prev <= 1'b1;
            end

            if (trig_hit) begin
                rptr      <= wptr - pretrig_q;         // oldest kept sample
                post_left <= LAST_ADDR - pretrig_q;
            end else if ((state == POST) && wr_en) begin
                post_left <= post_left - AW'(1);
            end

            if (fire) begin
                rptr     <= rptr + AW'(1);
                beat_cnt <= beat_cnt + AW'(1);
            end
        end
    end

    // NOTE: the buffer array has no reset so it maps onto block RAM; only the
    // read output register is cleared.
    always_ff @(posedge clkin) begin
        if (wr_en) mem[wptr] <= adc_data;
    end

    always_ff @(posedge clkin) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[ram_addr];
    end

endmodule

// File: tb/tb_adc_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_capture
//
// Directed bench for adc_capture. A background process drives adc_data as a
// ramp or constant; each capture pushes its expected 1024-beat window into a
// scoreboard queue, which is popped and compared on every readout transfer.
// ---------------------------------------------------------------------------
module tb_adc_capture;

    localparam int DEPTH = 1024;

    logic        clkin = 1'b0;
    logic        reset;
    logic [7:0]  adc_data;
    logic        start;
    logic [15:0] decim;
    logic [7:0]  trig_level;
    logic        trig_edge;
    logic        trig_force;
    logic [9:0]  pretrig;
    logic        busy;
    logic        done;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    // adc_data generator controls
    logic [7:0] gen_val     = 8'd0;
    logic [7:0] gen_start   = 8'd0;
    logic [7:0] gen_step    = 8'd1;
    logic       gen_restart = 1'b0;

    adc_capture #(.DW(8), .AW(10), .DIV_W(16)) dut (
        .clkin      (clkin),
        .reset      (reset),
        .adc_data   (adc_data),
        .start      (start),
        .decim      (decim),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .trig_force (trig_force),
        .pretrig    (pretrig),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready)
    );

    always #5 clkin = ~clkin;

    // New sample value 2 ns after each rising edge; a restart makes the value
    // seen by the next edge equal gen_start.
    initial begin
        adc_data = 8'd0;
        forever begin
            @(posedge clkin);
            #2;
            if (gen_restart) begin
                gen_val     = gen_start;
                gen_restart = 1'b0;
            end else begin
                gen_val = gen_val + gen_step;
            end
            adc_data = gen_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected window: beat n = (base + step*n) mod 256
    task automatic fill_exp(input int base, input int step);
        exp_q.delete();
        for (int n = 0; n < DEPTH; n++) exp_q.push_back((base + step * n) & 255);
    endtask

    task automatic do_start(input int dec, input int pre, input int lvl, input bit edg,
                            input int gs, input int gstep);
        @(posedge clkin); #1;
        decim      = 16'(dec);
        pretrig    = 10'(pre);
        trig_level = 8'(lvl);
        trig_edge  = edg;
        start      = 1'b1;
        @(posedge clkin); #1;
        start       = 1'b0;
        gen_start   = 8'(gs);
        gen_step    = 8'(gstep);
        gen_restart = 1'b1;
    endtask

    // Consume the readout, optionally with random backpressure, checking every
    // beat against the scoreboard and the hold rule while stalled.
    task automatic drain(input bit rnd, input string tag);
        int         beats = 0;
        bit         was_stalled = 1'b0;
        logic [7:0] held = 8'd0;
        int         expv;
        for (int cyc = 0; cyc < 20000 && beats < DEPTH; cyc++) begin
            @(negedge clkin);
            if (was_stalled) begin
                check($sformatf("%s_hold_valid", tag), 32'(rd_valid), 1);
                check($sformatf("%s_hold_data", tag), 32'(rd_data), 32'(held));
            end
            rd_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rd_valid && rd_ready) begin
                expv = exp_q.pop_front();
                check($sformatf("%s_beat%0d", tag, beats), 32'(rd_data), 32'(expv));
                beats++;
                was_stalled = 1'b0;
            end else begin
                was_stalled = rd_valid;
                held        = rd_data;
            end
        end
        check($sformatf("%s_beats", tag), 32'(beats), DEPTH);
        @(negedge clkin);
        rd_ready = 1'b1;
        check($sformatf("%s_done", tag), 32'(done), 1);
        check($sformatf("%s_busy_end", tag), 32'(busy), 0);
        check($sformatf("%s_valid_end", tag), 32'(rd_valid), 0);
        @(negedge clkin);
        check($sformatf("%s_done_once", tag), 32'(done), 0);
        check($sformatf("%s_no_extra", tag), 32'(rd_valid), 0);
        exp_q.delete();
    endtask

    // Watch a few cycles and report whether done ever pulsed
    task automatic watch_no_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clkin);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        bit got;

        reset      = 1'b1;
        start      = 1'b0;
        decim      = 16'd0;
        trig_level = 8'd0;
        trig_edge  = 1'b0;
        trig_force = 1'b0;
        pretrig    = 10'd0;
        rd_ready   = 1'b1;
        repeat (3) @(posedge clkin);
        @(negedge clkin);
        check("reset_busy",     32'(busy), 0);
        check("reset_done",     32'(done), 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_rd_data",  32'(rd_data), 0);
        @(posedge clkin); #1;
        reset = 1'b0;

        // Basic capture: trigger on value 128, beat0=28, beat100=128, beat1023=27
        fill_exp(28, 1);
        do_start(0, 100, 128, 1'b0, 0, 1);
        check("basic_busy_t1", 32'(busy), 1);
        drain(1'b0, "basic");

        // Decimation by 4, pretrig 0: beat0=128, step 4
        fill_exp(128, 4);
        do_start(3, 0, 128, 1'b0, 0, 1);
        drain(1'b0, "decim");

        // Same as basic, with random backpressure
        fill_exp(28, 1);
        do_start(0, 100, 128, 1'b0, 0, 1);
        drain(1'b1, "bp");

        // Falling edge on descending ramp: beat10=64
        fill_exp(74, -1);
        do_start(0, 10, 64, 1'b1, 255, -1);
        drain(1'b0, "fall");

        // Forced trigger 5 strobes after ARMED on a constant input
        fill_exp(8'h55, 0);
        do_start(0, 20, 128, 1'b0, 8'h55, 0);
        repeat (25) @(posedge clkin);
        #1 trig_force = 1'b1;
        @(posedge clkin); #1;
        trig_force = 1'b0;
        drain(1'b0, "force");

        // pretrig=1023 with force held through PRE: triggers on sample 1023,
        // which is the last beat
        trig_force = 1'b1;
        fill_exp(0, 1);
        do_start(0, 1023, 128, 1'b0, 0, 1);
        drain(1'b0, "pmax");
        trig_force = 1'b0;

        // Second start while ARMED is ignored
        fill_exp(128, 1);
        do_start(0, 0, 128, 1'b0, 0, 1);
        repeat (50) @(posedge clkin);
        #1;
        decim      = 16'd7;
        pretrig    = 10'd5;
        trig_level = 8'd10;
        trig_edge  = 1'b1;
        start      = 1'b1;
        @(posedge clkin); #1;
        start = 1'b0;
        drain(1'b0, "restart");

        // Reset while in POST
        do_start(0, 100, 128, 1'b0, 0, 1);
        repeat (140) @(posedge clkin);
        #1;
        check("post_busy_before", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clkin); #1;
        reset = 1'b0;
        @(negedge clkin);
        check("post_rst_busy",  32'(busy), 0);
        check("post_rst_valid", 32'(rd_valid), 0);
        watch_no_done("post_rst_no_done");

        // Reset mid-READOUT with rd_valid held high by backpressure
        rd_ready = 1'b0;
        do_start(0, 0, 128, 1'b0, 0, 1);
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clkin);
            got = rd_valid;
        end
        check("rdo_valid_seen", 32'(got), 1);
        @(posedge clkin); #1;
        reset = 1'b1;
        @(posedge clkin); #1;
        reset = 1'b0;
        @(negedge clkin);
        check("rdo_rst_busy",  32'(busy), 0);
        check("rdo_rst_valid", 32'(rd_valid), 0);
        check("rdo_rst_data",  32'(rd_data), 0);
        rd_ready = 1'b1;
        watch_no_done("rdo_rst_no_done");

        // start coincident with reset: reset wins
        @(posedge clkin); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clkin); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clkin);
        check("start_vs_reset_busy", 32'(busy), 0);
        @(negedge clkin);
        check("start_vs_reset_busy2", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
# adc_capture

Triggered sample-capture engine for the scope path, the receive-side counterpart of the DAC generator chain. Samples a parallel ADC bus on the PLL-derived sample clock and decimates it. Stores a pre/post-trigger window in an internal circular buffer, then streams the window out oldest-first over a valid/ready port to the host readout logic.

## Interface
- DW, 8, ADC sample width
- AW, 10, buffer address width; DEPTH = 2^AW samples
- DIV_W, 16, decimation counter width
- clkin  in  1  sample clock (PLL output); all logic on rising edge
- reset  in  1  synchronous, active-high reset
- adc_data  in  DW  ADC parallel sample, valid every clkin cycle
- start  in  1  one-cycle arm request; ignored while busy=1
- decim  in  DIV_W  store one sample every decim+1 cycles
- trig_level  in  DW  trigger threshold, unsigned
- trig_edge  in  1  0 = rising, 1 = falling
- trig_force  in  1  level-sensitive forced trigger, honoured only in ARMED
- pretrig  in  AW  samples kept before the trigger sample
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last readout beat
- rd_data  out  DW  readout sample
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts the beat

## Operation
- decim, trig_level, trig_edge and pretrig are latched on accepted start and held for the whole capture. Latched pretrig is clamped to DEPTH-1.
- Sample strobe: a counter is loaded so that a strobe fires on the first cycle after start, then every decim+1 cycles. decim=0 gives one strobe per cycle. Every strobe writes adc_data at wptr, and wptr increments mod DEPTH. wptr=0 at start.
- States: IDLE, PRE, ARMED, POST, READOUT.
- IDLE: busy=0, rd_valid=0. Accepted start -> PRE.
- PRE: counts strobes. Once pretrig samples are written -> ARMED. pretrig=0 -> ARMED on the cycle after start, with no sample written in PRE. Trigger conditions are ignored in PRE.
- ARMED: on each strobe, compare the current sample (cur) with the previously stored sample (prev).
  - Rising trigger: prev < level && cur >= level.
  - Falling trigger: prev > level && cur <= level.
  - Force trigger: trig_force=1 at the strobe.
  - The first sample of a capture has no prev and never edge-triggers.
- On a trigger strobe, the sample is stored, trig_addr = its address, and the state goes -> POST.
- POST: store DEPTH-1-pretrig further samples, then -> READOUT. If that count is 0 -> READOUT directly.
- READOUT: emit exactly DEPTH beats starting at address (trig_addr - pretrig) mod DEPTH, incrementing with wrap.
  - Beat n=pretrig is the trigger sample.
  - A beat transfers when rd_valid && rd_ready.
  - After the DEPTH-th transfer: done pulses, busy=0, state -> IDLE.
- Buffer is inferred synchronous RAM with 1-cycle read latency. Readout prefetches, so sustained rd_ready=1 gives one beat per cycle.
- No capture without a trigger: ARMED waits indefinitely, and only reset exits it.

## Timing
- Reset values: busy=0, done=0, rd_valid=0, rd_data=0, state IDLE, wptr=0. Buffer contents are not cleared.
- Reset in any state, including mid-READOUT with rd_valid=1, returns to IDLE on the next edge. No done pulse is produced.
- start at cycle t: busy=1 and the first strobe/write occur at t+1.
- A trigger strobe at cycle t puts the state in POST at t+1.
- rd_valid rises no later than 2 cycles after entering READOUT.
- While rd_valid=1 && rd_ready=0, rd_data and rd_valid hold stable.
- The last transfer at cycle t gives done=1, busy=0 and rd_valid=0 at t+1.
- start coincident with reset: reset wins.
- start while busy: no effect.
- trig_force asserted in PRE: ignored. If still high at the first ARMED strobe, it triggers on that strobe.

## Test plan
- Basic capture: DEPTH=1024; adc_data ramps +1 per cycle mod 256 from 0 at start+1; decim=0, pretrig=100, level=128, rising; rd_ready=1 -> trigger on sample value 128. Required readout: 1024 beats, beat0=28, beat100=128, beat1023=27. done pulses once.
- Decimation: same ramp with decim=3, pretrig=0, level=128 -> consecutive beats differ by 4, beat0=128.
- Falling and forced triggers:
  - Falling: descending ramp from 255, level=64, trig_edge=1, pretrig=10 -> beat10=64.
  - Forced: constant adc_data=0x55, trig_force pulsed 5 cycles after ARMED -> all beats 0x55, done asserted.
- Backpressure: rd_ready toggles pseudo-randomly -> beat sequence is identical to the rd_ready=1 run, rd_data is stable while stalled, and exactly 1024 transfers occur.
- Reset and start rules:
  - reset asserted in POST -> busy=0, rd_valid=0 next cycle, and no done pulse.
  - A second start during ARMED -> ignored, and the capture completes normally.
- Pretrig bounds:
  - pretrig=0 -> beat0 is the trigger sample.
  - pretrig=1023 (maximum) -> beat1023 is the trigger sample.
  - Any request above DEPTH-1 (only reachable with a wider pretrig input) clamps to 1023.
